// File: rtl/fpmul_arb_pkg.sv
// Shared defaults and the result-tracking entry for the FPMul issue arbiter.
package fpmul_arb_pkg;

  localparam int NREQ_DEF  = 2;   // VLIW issue slots sharing the multiplier
  localparam int LAT_DEF   = 25;  // fixed FPMul latency in cycles
  localparam int TAGW_DEF  = 5;   // destination-register tag width

  // Tracking fields are sized for the largest supported configuration
  // (up to 16 slots, 16-bit tags); narrower configs zero-extend into them.
  localparam int SLOT_MAXW = 4;
  localparam int TAG_MAXW  = 16;

  // One stage of the tracking shift pipeline: {valid, slot, tag}.
  typedef struct packed {
    logic                 valid;
    logic [SLOT_MAXW-1:0] slot;
    logic [TAG_MAXW-1:0]  tag;
  } trk_entry_t;

  // Index width that stays legal for a single-slot configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: searches req_i starting at ptr_i and
// returns a one-hot grant plus its index. With en_i low no grant is given.
module rr_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_any_o
);

  int cand;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = 0;
    if (en_i) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(ptr_i) + k) % NREQ;
        if (!grant_any_o && req_i[cand]) begin
          grant_any_o   = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = IDXW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/fpmul_issue_arbiter.sv
// Shares one fixed-latency FPMul among NREQ issue slots. Grants one slot per
// cycle round-robin, registers its operands toward the multiplier and tracks
// {valid, slot, tag} through a LAT-deep shift pipeline so the product can be
// returned with its owner's identity.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational from req_valid and
// may be given without regard to anything downstream; at most one bit is set,
// and none while rst or flush is high. The result side has no back-pressure:
// res_valid is a one-cycle strobe the consumer must take.
module fpmul_issue_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int LAT   = LAT_DEF,
  parameter  int TAGW  = TAGW_DEF,
  localparam int SLOTW = idx_width(NREQ),
  localparam int CNTW  = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]   req_ready,
  input  logic              flush,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_out,
  output logic              res_valid,
  output logic [SLOTW-1:0]  res_slot,
  output logic [TAGW-1:0]   res_tag,
  output logic [31:0]       res_data,
  output logic [CNTW-1:0]   inflight
);

  logic [SLOTW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  trk_entry_t       pipe_q [LAT];
  trk_entry_t       pipe_d [LAT];

  logic             arb_en;
  logic [NREQ-1:0]  grant;
  logic [SLOTW-1:0] gidx;
  logic             transfer;
  trk_entry_t       last;

  // Issue is blocked entirely during reset and flush.
  assign arb_en = ~(rst | flush);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (SLOTW)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (arb_en),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .grant_any_o (transfer)
  );

  // The grant only lands on a requesting slot, so any grant is a transfer.
  assign req_ready = grant;

  // Pointer moves past the winner only when something actually transferred.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (gidx == SLOTW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Operand registers load the winner's operands and otherwise hold.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (transfer) begin
      mul_a_d = req_a[int'(gidx)*32 +: 32];
      mul_b_d = req_b[int'(gidx)*32 +: 32];
    end
  end

  // Tracking pipeline shifts every cycle; flush empties it.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      pipe_d[k] = '0;
    end
    if (!flush) begin
      pipe_d[0].valid = transfer;
      pipe_d[0].slot  = SLOT_MAXW'(gidx);
      pipe_d[0].tag   = TAG_MAXW'(req_tag[int'(gidx)*TAGW +: TAGW]);
      for (int k = 1; k < LAT; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  // In-flight count follows issue and return; simultaneous events cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (transfer && !res_valid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!transfer && res_valid) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers; reset wins over flush and any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      cnt_q    <= cnt_d;
      for (int k = 0; k < LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign last      = pipe_q[LAT-1];
  assign res_valid = last.valid;
  assign res_slot  = last.slot[SLOTW-1:0];
  assign res_tag   = last.tag[TAGW-1:0];
  assign res_data  = mul_out;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign inflight  = cnt_q;

  // Upper tracking bits are always zero for configs below the maximum.
  logic unused_trk_bits;
  assign unused_trk_bits = ^{last.slot, last.tag};

endmodule

// File: tb/tb_fpmul_issue_arbiter.sv
// Directed bench for fpmul_issue_arbiter with a queue-based scoreboard.
module tb_fpmul_issue_arbiter;

  localparam int NREQ = 2;
  localparam int LAT  = 25;
  localparam int TAGW = 5;
  localparam int EW   = 32 + 1 + TAGW + 32;  // {due cycle, slot, tag, data}

  localparam logic [31:0] F_1P5 = 32'h3FC0_0000;
  localparam logic [31:0] F_2   = 32'h4000_0000;
  localparam logic [31:0] F_3   = 32'h4040_0000;
  localparam logic [31:0] F_4   = 32'h4080_0000;
  localparam logic [31:0] F_6   = 32'h40C0_0000;
  localparam logic [31:0] F_9   = 32'h4110_0000;
  localparam logic [31:0] F_18  = 32'h4190_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] IDLE_OUT = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;
  logic [31:0]          mul_out;
  logic                 res_valid;
  logic [0:0]           res_slot;
  logic [TAGW-1:0]      res_tag;
  logic [31:0]          res_data;
  logic [4:0]           inflight;

  logic                 sv [NREQ];
  logic [31:0]          sa [NREQ];
  logic [31:0]          sb [NREQ];
  logic [31:0]          sp [NREQ];
  logic [TAGW-1:0]      st [NREQ];

  assign req_valid = {sv[1], sv[0]};
  assign req_a     = {sa[1], sa[0]};
  assign req_b     = {sb[1], sb[0]};
  assign req_tag   = {st[1], st[0]};

  fpmul_issue_arbiter #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .TAGW (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .flush     (flush),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_slot  (res_slot),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .inflight  (inflight)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int max_infl = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- fake FPMul: plays back hand-computed products ----------------
  logic [31:0] sched [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    mul_out = sched[cyc % 64];
  end

  // ---------------- driver tasks ----------------
  task automatic set_slot(input int i, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p,
                          input logic [TAGW-1:0] t);
    sv[i] = v;
    sa[i] = a;
    sb[i] = b;
    sp[i] = p;
    st[i] = t;
  endtask

  task automatic idle_slots();
    set_slot(0, 1'b0, 32'h0, 32'h0, 32'h0, '0);
    set_slot(1, 1'b0, 32'h0, 32'h0, 32'h0, '0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0]   exp_q [$];
  logic [EW-1:0]   ent;
  logic [NREQ-1:0] m_ready;
  logic [31:0]     m_a, m_b;
  int              m_ptr, m_infl, gi, c;
  logic            m_live = 1'b0;
  logic            post_rst = 1'b0;
  logic            exp_rv, tr;

  always @(negedge clk) begin
    // expected grant for this cycle
    m_ready = '0;
    gi = 0;
    if (!rst && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (m_ready == '0 && sv[c]) begin
          m_ready[c] = 1'b1;
          gi = c;
        end
      end
    end
    tr = (m_ready != '0);
    chk("req_ready", 64'(req_ready), 64'(m_ready));

    // expected result and state for this cycle
    exp_rv = 1'b0;
    if (m_live) begin
      exp_rv = (exp_q.size() > 0) && (int'(exp_q[0][EW-1:EW-32]) == cyc);
      chk("res_valid", 64'(res_valid), 64'(exp_rv));
      if (exp_rv) begin
        ent = exp_q.pop_front();
        if (res_valid) begin
          chk("res_slot", 64'(res_slot), 64'(ent[37]));
          chk("res_tag", 64'(res_tag), 64'(ent[36:32]));
          chk("res_data", 64'(res_data), 64'(ent[31:0]));
        end
      end
      chk("inflight", 64'(inflight), 64'(m_infl));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      if (post_rst) begin
        chk("res_slot_after_rst", 64'(res_slot), 64'd0);
        chk("res_tag_after_rst", 64'(res_tag), 64'd0);
      end
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
    end
    sched[cyc % 64] = IDLE_OUT;

    // advance the model across the coming edge
    post_rst = 1'b0;
    if (rst) begin
      m_ptr  = 0;
      m_a    = '0;
      m_b    = '0;
      m_infl = 0;
      exp_q.delete();
      m_live   = 1'b1;
      post_rst = 1'b1;
    end else if (flush) begin
      m_infl = 0;
      exp_q.delete();
    end else begin
      if (tr) begin
        exp_q.push_back({32'(cyc + LAT), 1'(gi), st[gi], sp[gi]});
        sched[(cyc + LAT) % 64] = sp[gi];
        m_ptr = (gi + 1) % NREQ;
        m_a   = sa[gi];
        m_b   = sb[gi];
      end
      m_infl = m_infl + (tr ? 1 : 0) - (exp_rv ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) sched[i] = IDLE_OUT;
    mul_out = IDLE_OUT;
    rst   = 1'b1;
    flush = 1'b0;
    idle_slots();
    step(3);
    rst = 1'b0;

    // single op from slot0: 2.0 * 9.0, tag 3; then operands must hold
    set_slot(0, 1'b1, F_2, F_9, F_18, 5'd3);
    #1;
    chk("first_grant", 64'(req_ready), 64'b01);
    step(1);
    idle_slots();
    step(30);
    chk("mul_a_hold", 64'(mul_a), 64'(F_2));
    chk("mul_b_hold", 64'(mul_b), 64'(F_9));

    // both slots busy: alternating grants, inflight reaches LAT
    max_infl = 0;
    for (int i = 0; i < 40; i++) begin
      set_slot(0, 1'b1, F_2, F_9, F_18, 5'(i));
      set_slot(1, 1'b1, F_3, F_HALF, F_1P5, 5'(i + 7));
      step(1);
    end
    idle_slots();
    step(30);
    chk("inflight_peak_both", 64'(max_infl), 64'(LAT));

    // slot1 alone: granted every cycle, inflight holds at LAT
    max_infl = 0;
    for (int i = 0; i < 30; i++) begin
      set_slot(1, 1'b1, F_1P5, F_4, F_6, 5'(31 - i));
      step(1);
    end
    idle_slots();
    step(30);
    chk("inflight_peak_slot1", 64'(max_infl), 64'(LAT));

    // five ops then flush; requests held high during flush get no grant
    for (int i = 0; i < 5; i++) begin
      set_slot(0, 1'b1, F_1P5, F_4, F_6, 5'(i + 10));
      step(1);
    end
    idle_slots();
    step(10);
    flush = 1'b1;
    set_slot(0, 1'b1, F_2, F_9, F_18, 5'd20);
    set_slot(1, 1'b1, F_3, F_HALF, F_1P5, 5'd21);
    #1;
    chk("ready_during_flush", 64'(req_ready), 64'b00);
    step(1);
    flush = 1'b0;
    idle_slots();
    chk("inflight_after_flush", 64'(inflight), 64'd0);
    step(30);
    set_slot(1, 1'b1, F_3, F_HALF, F_1P5, 5'd9);
    step(1);
    idle_slots();
    step(30);

    // reset with twelve ops in flight; first grant afterwards is slot0
    for (int i = 0; i < 12; i++) begin
      set_slot(0, 1'b1, F_2, F_9, F_18, 5'(i));
      set_slot(1, 1'b1, F_1P5, F_4, F_6, 5'(i + 16));
      step(1);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    chk("grant_after_rst", 64'(req_ready), 64'b01);
    chk("inflight_after_rst", 64'(inflight), 64'd0);
    step(2);
    idle_slots();
    step(30);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpmul_issue_arbiter.md
FPMUL_ISSUE_ARBITER -- requirements
Module: fpmul_issue_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of VLIW issue slots sharing the multiplier.
REQ-002 Parameter LAT, default 25: fixed FPMul latency in clk cycles, from operand presentation to result.
REQ-003 Parameter TAGW, default 5: destination-register tag width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port req_valid, input, NREQ: per-slot multiply request.
REQ-008 Port req_a, input, NREQ*32: per-slot operand A, IEEE-754 single; slot i occupies bits [32i+31:32i].
REQ-009 Port req_b, input, NREQ*32: per-slot operand B, with the same packing as req_a.
REQ-010 Port req_tag, input, NREQ*TAGW: per-slot destination tag.
REQ-011 Port req_ready, output, NREQ: grant, one-hot or zero.
REQ-012 Port flush, input, 1: kill all in-flight operations.
REQ-013 Port mul_a, output, 32: registered operand to FPMul I1.
REQ-014 Port mul_b, output, 32: registered operand to FPMul I2.
REQ-015 Port mul_out, input, 32: FPMul out.
REQ-016 Port res_valid, output, 1: result strobe.
REQ-017 Port res_slot, output, clog2(NREQ): slot that issued the returning operation.
REQ-018 Port res_tag, output, TAGW: tag of the returning operation.
REQ-019 Port res_data, output, 32: product.
REQ-020 Port inflight, output, clog2(LAT+1): count of operations in the pipeline.

Function
REQ-021 Issue: the block SHALL grant at most one slot per cycle; a transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-022 Arbitration: req_ready SHALL be combinational round-robin over req_valid, starting the search at the rr pointer; the pointer SHALL advance to (granted slot + 1) mod NREQ only on a transfer.
REQ-023 Gating: req_ready SHALL be all-zero while rst or flush is high.
REQ-024 Operand capture: on a transfer, mul_a and mul_b SHALL load the granted slot's operands at that edge; with no transfer they SHALL hold their previous values.
REQ-025 Tracking: a LAT-deep shift pipeline of {valid, slot, tag} SHALL advance every cycle; stage 0 SHALL load {transfer, granted slot, granted tag}.
REQ-026 Return: res_valid, res_slot and res_tag SHALL be driven from the final pipeline stage; res_data SHALL equal mul_out in the same cycle, so a result is presented exactly LAT cycles after its transfer edge.
REQ-027 Back-pressure: there is none on the result side; the block SHALL never stall the pipeline, and the consumer must accept res_valid every cycle.
REQ-028 In-flight count: inflight SHALL increment on a transfer, decrement when res_valid is high, and stay unchanged when both events occur in the same cycle; maximum value is LAT.
REQ-029 Flush: on an edge with flush high, all pipeline valid bits and inflight SHALL clear and no transfer SHALL occur; res_valid SHALL stay low until new issues return; the rr pointer and mul_a/mul_b SHALL hold.
REQ-030 Idle slots: the arbiter SHALL skip slots with req_valid low; a single active slot SHALL be granted every cycle, giving full throughput of one issue per cycle.
REQ-031 Tag handling: tags are opaque to the block; it SHALL neither check nor deduplicate them.

Reset
REQ-032 On an edge with rst high, the block SHALL clear all pipeline valid bits, set the rr pointer to 0, and set mul_a, mul_b and inflight to 0.
REQ-033 As a result of REQ-032, res_valid SHALL be 0 and res_slot and res_tag SHALL be 0 in the cycle after reset.
REQ-034 rst SHALL take priority over flush and over any transfer.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight results; no res_valid SHALL appear for them.

Structure
REQ-036 Shared package fpmul_arb_pkg SHALL hold LAT, NREQ and TAGW defaults plus the pipeline-entry typedef {valid, slot, tag}.
REQ-037 A single sub-module rr_arbiter (NREQ-wide, pointer-based, one-hot grant) SHALL implement REQ-022.
REQ-038 All other logic, meaning the operand registers, tracking pipeline and counter, SHALL be inline.

Verification
REQ-039 Reset, then slot0 requests a=0x40000000 (2.0), b=0x41100000 (9.0), tag=3 -> req_ready=01; 25 cycles later res_valid=1, slot=0, tag=3, res_data=0x41900000.
REQ-040 Both slots valid continuously, pointer=0 -> grants alternate 01,10,01,...; results return in issue order, one per cycle after 25 cycles; inflight saturates at 25.
REQ-041 Slot1 alone valid for 30 cycles -> granted every cycle; inflight reaches 25 and holds there while issue and return coincide.
REQ-042 Issue 5 ops, assert flush 10 cycles later -> inflight=0 next cycle; no res_valid for the flushed ops; a subsequent issue returns normally.
REQ-043 rst pulsed while 12 ops are in flight -> no res_valid afterwards; pointer=0; with both slots valid, the first grant is slot0.
REQ-044 Operand hold: one transfer followed by idle cycles -> mul_a and mul_b unchanged, res_valid for exactly one cycle.
